// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int unsigned FWFT_OFF = 0;
  localparam int unsigned FWFT_ON  = 1;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

  // Width needed to hold an occupancy value in 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return clog2(depth + 1);
  endfunction

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write port, asynchronous read port.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with arbitrary depth, registered occupancy/threshold flags,
// overflow/underflow pulses and a selectable first-word-fall-through read port.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2,
  parameter int unsigned FWFT       = FWFT_OFF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cs,
  input  logic                               wr_en,
  input  logic                               rd_en,
  input  logic [DATA_WIDTH-1:0]              data_in,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               full,
  output logic                               empty,
  output logic                               almost_full,
  output logic                               almost_empty,
  output logic [cnt_width(FIFO_DEPTH)-1:0]   count,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int unsigned CW = cnt_width(FIFO_DEPTH);
  localparam int unsigned AW = addr_width(FIFO_DEPTH);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [CW-1:0]         count_next;
  logic [DATA_WIDTH-1:0] rd_data;

  // Explicit wrap so non-power-of-2 depths never address past the last entry.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    rd_acc     = cs & rd_en & ~empty;
    wr_acc     = cs & wr_en & (~full | rd_acc);
    count_next = count + CW'(wr_acc) - CW'(rd_acc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      count        <= count_next;
      full         <= (count_next == CW'(FIFO_DEPTH));
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= CW'(AF_THRESH));
      almost_empty <= (count_next <= CW'(AE_THRESH));
      overflow     <= cs & wr_en & ~wr_acc;
      underflow    <= cs & rd_en & ~rd_acc;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      assign data_out = empty ? '0 : rd_data;
    end else begin : g_reg
      // Full FIFO with simultaneous read+write: the async read sees the old
      // word at rd_ptr before the write lands, so the head is not clobbered.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)        data_out <= '0;
        else if (rd_acc) data_out <= rd_data;
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench: a registered-read DEPTH=4 FIFO and an FWFT DEPTH=3 FIFO
// driven in parallel and compared each cycle against queue-based models.
module tb_sync_fifo_flags;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] din;

  logic [31:0] a_dout, b_dout;
  logic        a_full, a_empty, a_af, a_ae, a_of, a_uf;
  logic        b_full, b_empty, b_af, b_ae, b_of, b_uf;
  logic [2:0]  a_count;
  logic [1:0]  b_count;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 0;

  sync_fifo_flags #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (4),
    .AF_THRESH  (3),
    .AE_THRESH  (1),
    .FWFT       (0)
  ) dut_a (
    .clk (clk), .rst (rst), .cs (cs), .wr_en (wr_en), .rd_en (rd_en),
    .data_in (din), .data_out (a_dout), .full (a_full), .empty (a_empty),
    .almost_full (a_af), .almost_empty (a_ae), .count (a_count),
    .overflow (a_of), .underflow (a_uf)
  );

  sync_fifo_flags #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (3),
    .AF_THRESH  (2),
    .AE_THRESH  (0),
    .FWFT       (1)
  ) dut_b (
    .clk (clk), .rst (rst), .cs (cs), .wr_en (wr_en), .rd_en (rd_en),
    .data_in (din), .data_out (b_dout), .full (b_full), .empty (b_empty),
    .almost_full (b_af), .almost_empty (b_ae), .count (b_count),
    .overflow (b_of), .underflow (b_uf)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: plain queues and the acceptance rules.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] exp_da = '0;
  bit exp_ofa = 0, exp_ufa = 0, exp_ofb = 0, exp_ufb = 0;

  always @(posedge clk or negedge rst) begin
    bit ra, wa, rb, wb;
    if (!rst) begin
      qa.delete(); qb.delete();
      exp_da = '0;
      exp_ofa = 0; exp_ufa = 0; exp_ofb = 0; exp_ufb = 0;
    end else begin
      ra = cs && rd_en && (qa.size() > 0);
      wa = cs && wr_en && ((qa.size() < 4) || ra);
      exp_ofa = cs && wr_en && !wa;
      exp_ufa = cs && rd_en && !ra;
      if (ra) exp_da = qa.pop_front();
      if (wa) qa.push_back(din);
      rb = cs && rd_en && (qb.size() > 0);
      wb = cs && wr_en && ((qb.size() < 3) || rb);
      exp_ofb = cs && wr_en && !wb;
      exp_ufb = cs && rd_en && !rb;
      if (rb) void'(qb.pop_front());
      if (wb) qb.push_back(din);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("a_count", a_count, qa.size());
      chk("a_full", a_full, qa.size() == 4);
      chk("a_empty", a_empty, qa.size() == 0);
      chk("a_almost_full", a_af, qa.size() >= 3);
      chk("a_almost_empty", a_ae, qa.size() <= 1);
      chk("a_overflow", a_of, exp_ofa);
      chk("a_underflow", a_uf, exp_ufa);
      chk("a_data_out", a_dout, exp_da);
      chk("b_count", b_count, qb.size());
      chk("b_full", b_full, qb.size() == 3);
      chk("b_empty", b_empty, qb.size() == 0);
      chk("b_almost_full", b_af, qb.size() >= 2);
      chk("b_almost_empty", b_ae, qb.size() == 0);
      chk("b_overflow", b_of, exp_ofb);
      chk("b_underflow", b_uf, exp_ufb);
      chk("b_data_out", b_dout, (qb.size() > 0) ? qb[0] : 32'd0);
    end
  end

  // Drive one cycle's request, then return 1 time unit after the edge that took it.
  task automatic cyc(input logic c, input logic w, input logic r, input logic [31:0] d);
    cs = c; wr_en = w; rd_en = r; din = d;
    @(posedge clk);
    #1;
    cs = 0; wr_en = 0; rd_en = 0;
  endtask

  initial begin
    logic [31:0] seq[4];
    logic [31:0] seq2[4];
    int unsigned wp;
    seq  = '{32'd1, 32'd2, 32'd4, 32'd8};
    seq2 = '{32'd2, 32'd4, 32'd8, 32'hA};
    rst = 1; cs = 0; wr_en = 0; rd_en = 0; din = '0;
    #1 rst = 0;
    #3;
    chk("rst_count", a_count, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_ae", a_ae, 1);
    chk("rst_af", a_af, 0);
    chk("rst_dout", a_dout, 0);
    chk("rst_of_uf", {a_of, a_uf}, 0);
    @(negedge clk); #2 rst = 1;
    @(posedge clk); #1 cmp_en = 1;

    // Fill 1,2,4,8 and watch the threshold flags move.
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, seq[i]);
      chk("fill_count", a_count, i + 1);
      if (i == 1) chk("fill_ae_falls", {a_ae, a_af}, 2'b00);
      if (i == 2) chk("fill_af_rises", {a_af, a_full}, 2'b10);
      if (i == 3) chk("fill_full", a_full, 1);
    end
    cyc(1, 1, 0, 32'd16);
    chk("ovf_pulse", a_of, 1);
    chk("ovf_count", a_count, 4);
    cyc(0, 0, 0, 0);
    chk("ovf_clear", a_of, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 1, 0);
      chk("drain_data", a_dout, seq[i]);
    end
    chk("drain_empty", a_empty, 1);

    cyc(1, 0, 1, 0);
    chk("udf_pulse", a_uf, 1);
    chk("udf_hold", a_dout, 8);
    cyc(1, 1, 1, 32'd5);
    chk("rw_empty_udf", a_uf, 1);
    chk("rw_empty_count", a_count, 1);
    cyc(1, 0, 1, 0);
    chk("rd_five", a_dout, 5);

    for (int i = 0; i < 4; i++) cyc(1, 1, 0, seq[i]);
    cyc(1, 1, 1, 32'hA);
    chk("full_rw_data", a_dout, 1);
    chk("full_rw_count", a_count, 4);
    chk("full_rw_no_ovf", a_of, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 1, 0);
      chk("wrap_data", a_dout, seq2[i]);
    end

    // FWFT instance: word visible without a read, then streaming pairs.
    cyc(1, 1, 0, 32'd7);
    chk("fwft_first", b_dout, 7);
    chk("fwft_count1", b_count, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 1, 32'd100 + 32'(i));
      chk("fwft_pair_data", b_dout, 32'd100 + 32'(i));
      chk("fwft_pair_count", b_count, 1);
    end
    cyc(1, 0, 1, 0);
    chk("fwft_empty_zero", {b_empty, b_dout}, {1'b1, 32'd0});

    wp = 1;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) wp = $urandom_range(0, 3);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) < wp,
          $urandom_range(0, 3) < (3 - wp), $urandom);
    end

    // Asynchronous reset in the middle of a cycle with data held.
    repeat (5) cyc(1, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 32'h50 + 32'(i));
    chk("pre_rst_count", a_count, 3);
    #2 rst = 0;
    #1;
    chk("async_count", a_count, 0);
    chk("async_flags", {a_empty, a_full, a_ae, a_af}, 4'b1010);
    chk("async_b_count", b_count, 0);
    chk("async_b_empty", b_empty, 1);
    #3 rst = 1;
    @(posedge clk); #1;
    cyc(1, 0, 1, 0);
    chk("post_rst_udf", a_uf, 1);
    chk("post_rst_b_udf", b_uf, 1);
    cyc(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
